// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the fetch stage (IF, read-only)
//   and the data stage (D, load/store). One access is in flight at a time;
//   read latency is absorbed in WAIT and the result is returned with a
//   one-cycle Grant/Done pulse. Stall gates the CPU pipeline while either
//   requester is waiting.
//
//   Ports
//     Clock, Reset        rising-edge clock, async active-low reset
//     IF_Req/Addr         fetch request (level, held until IF_Grant)
//     IF_Grant/RData      fetch complete pulse and fetched word (held)
//     D_Req/Write/ByteSel/Addr/WData   data request (held until D_Done)
//     D_Done/RData        data complete pulse and load word (held)
//     Mem_*               memory macro port
//     Stall               (IF_Req & ~IF_Grant) | (D_Req & ~D_Done)
//     Perf_IF/D/Stall     event counters, present only with ARB_PERF_EN
//
//   Build option: define ARB_PERF_EN to synthesise the three perf counters;
//   without it the Perf_* ports read 0.
//
//   Parameter ranges: MEM_LAT 1..4, STARVE_MAX 1..15.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Addr,
  output logic              IF_Grant,
  output logic [DATA_W-1:0] IF_RData,
  input  logic              D_Req,
  input  logic              D_Write,
  input  logic [1:0]        D_ByteSel,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D_WData,
  output logic              D_Done,
  output logic [DATA_W-1:0] D_RData,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [1:0]        Mem_ByteSel,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Stall,
  output logic [31:0]       Perf_IF,
  output logic [31:0]       Perf_D,
  output logic [31:0]       Perf_Stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state, stateNext;
  logic              winD;        // latched winner: 1 = data side, 0 = fetch
  logic [ADDR_W-1:0] addrQ;
  logic              weQ;
  logic [1:0]        bselQ;
  logic [DATA_W-1:0] wdataQ;
  logic [1:0]        waitCnt;
  logic [3:0]        starveCnt;
  logic [DATA_W-1:0] ifRDataQ, dRDataQ;

  logic ifReqEff, dReqEff, pickD, pickIf;

  // A requester currently receiving its pulse is not a new request.
  assign ifReqEff = IF_Req & ~IF_Grant;
  assign dReqEff  = D_Req  & ~D_Done;
  assign pickD    = dReqEff & (~ifReqEff | (starveCnt < STARVE_LIM));
  assign pickIf   = ~pickD & ifReqEff;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (pickD | pickIf) stateNext = ISSUE;
      ISSUE: stateNext = weQ ? RESP : WAIT;
      WAIT:  if (waitCnt == 2'd0) stateNext = RESP;
      RESP:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Payload latch, latency counter, read-data capture, starvation tracking.
  // Reset clears everything so a response in flight is simply dropped.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      winD      <= 1'b0;
      addrQ     <= '0;
      weQ       <= 1'b0;
      bselQ     <= 2'b00;
      wdataQ    <= '0;
      waitCnt   <= 2'd0;
      starveCnt <= 4'd0;
      ifRDataQ  <= '0;
      dRDataQ   <= '0;
    end else begin
      case (state)
        IDLE: if (pickD | pickIf) begin
          winD  <= pickD;
          addrQ <= pickD ? D_Addr : IF_Addr;
          weQ   <= pickD & D_Write;
          bselQ <= pickD ? D_ByteSel : 2'b00;
          if (pickD) wdataQ <= D_WData;
          if (pickD && ifReqEff && starveCnt != 4'd15)
            starveCnt <= starveCnt + 4'd1;
        end
        ISSUE: waitCnt <= LAT_INIT;
        WAIT: begin
          if (waitCnt == 2'd0) begin
            if (winD) dRDataQ  <= Mem_RData;
            else      ifRDataQ <= Mem_RData;
          end else begin
            waitCnt <= waitCnt - 2'd1;
          end
        end
        RESP: if (!winD) starveCnt <= 4'd0;
        default: ;
      endcase
    end
  end

  assign IF_Grant    = (state == RESP) & ~winD;
  assign D_Done      = (state == RESP) &  winD;
  assign IF_RData    = ifRDataQ;
  assign D_RData     = dRDataQ;
  assign Mem_En      = (state == ISSUE);
  assign Mem_We      = (state == ISSUE) & weQ;
  assign Mem_ByteSel = bselQ;
  assign Mem_Addr    = addrQ;
  assign Mem_WData   = wdataQ;
  assign Stall       = (IF_Req & ~IF_Grant) | (D_Req & ~D_Done);

`ifdef ARB_PERF_EN
  logic [31:0] perfIf, perfD, perfStall;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      perfIf    <= '0;
      perfD     <= '0;
      perfStall <= '0;
    end else begin
      if (IF_Grant) perfIf    <= perfIf + 32'd1;
      if (D_Done)   perfD     <= perfD + 32'd1;
      if (Stall)    perfStall <= perfStall + 32'd1;
    end
  end

  assign Perf_IF    = perfIf;
  assign Perf_D     = perfD;
  assign Perf_Stall = perfStall;
`else
  assign Perf_IF    = 32'd0;
  assign Perf_D     = 32'd0;
  assign Perf_Stall = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// strobes and completions into queues; two monitors pop and compare.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
  localparam int P    = 3 + LAT;   // cycles per load transaction incl. IDLE

  logic        Clock = 1'b0, Reset = 1'b0;
  logic        IF_Req = 1'b0, IF_Grant;
  logic [31:0] IF_Addr = '0, IF_RData;
  logic        D_Req = 1'b0, D_Write = 1'b0, D_Done;
  logic [1:0]  D_ByteSel = 2'b00;
  logic [31:0] D_Addr = '0, D_WData = '0, D_RData;
  logic        Mem_En, Mem_We, Stall;
  logic [1:0]  Mem_ByteSel;
  logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
  logic [31:0] Perf_IF, Perf_D, Perf_Stall;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .Clock(Clock), .Reset(Reset),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Grant(IF_Grant), .IF_RData(IF_RData),
    .D_Req(D_Req), .D_Write(D_Write), .D_ByteSel(D_ByteSel), .D_Addr(D_Addr),
    .D_WData(D_WData), .D_Done(D_Done), .D_RData(D_RData),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_ByteSel(Mem_ByteSel), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Stall(Stall),
    .Perf_IF(Perf_IF), .Perf_D(Perf_D), .Perf_Stall(Perf_Stall));

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Memory model: read data appears LAT cycles after the Mem_En cycle.
  logic [31:0] memArr [0:63];
  logic [31:0] rdPipe [0:LAT-1];
  always @(posedge Clock) begin
    rdPipe[0] <= (Mem_En && !Mem_We) ? memArr[Mem_Addr[7:2]] : 32'hBADC0DE0;
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign Mem_RData = rdPipe[LAT-1];

  typedef struct {bit isD; logic [31:0] data; int cyc;} resp_t;
  typedef struct {logic [31:0] addr; bit we; logic [1:0] bsel; logic [31:0] wdata; int cyc;} mreq_t;
  typedef struct {logic [31:0] addr; bit wr; logic [1:0] bsel; logic [31:0] wdata;} dcmd_t;

  resp_t       respQ[$];
  mreq_t       memQ[$];
  logic [31:0] ifCmds[$];
  dcmd_t       dCmds[$];
  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pushResp(input bit isD, input logic [31:0] data, input int c);
    resp_t r; r.isD = isD; r.data = data; r.cyc = c; respQ.push_back(r);
  endtask

  task automatic pushMem(input logic [31:0] a, input bit we, input logic [1:0] bs,
                         input logic [31:0] wd, input int c);
    mreq_t m; m.addr = a; m.we = we; m.bsel = bs; m.wdata = wd; m.cyc = c; memQ.push_back(m);
  endtask

  task automatic pushD(input logic [31:0] a, input bit wr, input logic [1:0] bs, input logic [31:0] wd);
    dcmd_t c; c.addr = a; c.wr = wr; c.bsel = bs; c.wdata = wd; dCmds.push_back(c);
  endtask

  // Completion monitor
  initial forever begin
    resp_t e;
    logic [31:0] got;
    @(negedge Clock);
    if (Reset && (IF_Grant || D_Done)) begin
      tests++;
      if (respQ.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: cyc=%0d grant=%b done=%b", cyc, IF_Grant, D_Done);
      end else begin
        e = respQ.pop_front();
        got = D_Done ? D_RData : IF_RData;
        if ((IF_Grant && D_Done) || (D_Done != e.isD) || (got !== e.data) ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          fails++;
          $display("FAIL resp: got isD=%0d data=%h cyc=%0d, expected isD=%0d data=%h cyc=%0d",
                   D_Done, got, cyc, e.isD, e.data, e.cyc);
        end
      end
    end
  end

  // Memory strobe monitor
  initial forever begin
    mreq_t m;
    @(negedge Clock);
    if (Reset && Mem_En) begin
      tests++;
      if (memQ.size() == 0) begin
        fails++;
        $display("FAIL mem_unexpected: cyc=%0d addr=%h", cyc, Mem_Addr);
      end else begin
        m = memQ.pop_front();
        if (Mem_Addr !== m.addr || Mem_We !== m.we || Mem_ByteSel !== m.bsel ||
            (m.we && Mem_WData !== m.wdata) || (m.cyc >= 0 && cyc != m.cyc)) begin
          fails++;
          $display("FAIL mem: got addr=%h we=%b bs=%b wd=%h cyc=%0d, expected addr=%h we=%b bs=%b wd=%h cyc=%0d",
                   Mem_Addr, Mem_We, Mem_ByteSel, Mem_WData, cyc, m.addr, m.we, m.bsel, m.wdata, m.cyc);
        end
      end
    end
  end

  task automatic waitPulse(input bit isD);
    int n = 0;
    do begin @(negedge Clock); n++; end while (!(isD ? D_Done : IF_Grant) && n < 200);
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL timeout_%s: no pulse within 200 cycles", isD ? "done" : "grant");
    end
  endtask

  task automatic runIf();
    while (ifCmds.size() > 0) begin
      IF_Addr = ifCmds.pop_front();
      IF_Req  = 1'b1;
      waitPulse(1'b0);
      @(posedge Clock); #1;
    end
    IF_Req = 1'b0;
  endtask

  task automatic runD();
    dcmd_t c;
    while (dCmds.size() > 0) begin
      c = dCmds.pop_front();
      D_Addr = c.addr; D_Write = c.wr; D_ByteSel = c.bsel; D_WData = c.wdata;
      D_Req  = 1'b1;
      waitPulse(1'b1);
      @(posedge Clock); #1;
    end
    D_Req = 1'b0;
  endtask

  task automatic startCycle(output int s);
    repeat (3) @(posedge Clock);
    #1 s = cyc;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_grant"}, {31'd0, IF_Grant}, 32'd0);
    check({tag, "_done"},  {31'd0, D_Done},   32'd0);
    check({tag, "_memen"}, {30'd0, Mem_En, Mem_We}, 32'd0);
    check({tag, "_addr"},  Mem_Addr,  32'd0);
    check({tag, "_wdata"}, Mem_WData, 32'd0);
    check({tag, "_bsel"},  {30'd0, Mem_ByteSel}, 32'd0);
    check({tag, "_ifrd"},  IF_RData,  32'd0);
    check({tag, "_drd"},   D_RData,   32'd0);
    check({tag, "_stall"}, {31'd0, Stall}, 32'd0);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 64; i++) memArr[i] = 32'hA000_0000 | i;
    memArr[4] = 32'h2002_000A;

    // Reset state
    repeat (3) @(posedge Clock);
    #1 checkAllZero("reset");
    @(negedge Clock) Reset = 1'b1;

    // Single fetch; Stall high until the grant cycle
    startCycle(s);
    pushMem(32'h10, 1'b0, 2'b00, '0, s + 1);
    pushResp(1'b0, 32'h2002_000A, s + 2 + LAT);
    ifCmds.push_back(32'h10);
    fork
      runIf();
      for (int k = 0; k <= 2 + LAT; k++) begin
        @(negedge Clock);
        check($sformatf("stall_fetch_k%0d", k), {31'd0, Stall}, (k < 2 + LAT) ? 32'd1 : 32'd0);
      end
    join

    // Contention: data load wins first, fetch follows
    startCycle(s);
    pushMem(32'h40, 1'b0, 2'b00, '0, s + 1);
    pushResp(1'b1, 32'hA000_0010, s + 2 + LAT);
    pushMem(32'h20, 1'b0, 2'b00, '0, s + 4 + LAT);
    pushResp(1'b0, 32'hA000_0008, s + 5 + 2 * LAT);
    pushD(32'h40, 1'b0, 2'b00, '0);
    ifCmds.push_back(32'h20);
    fork runIf(); runD(); join

    // Byte store: done 2 cycles after sampling, D_RData untouched
    startCycle(s);
    pushMem(32'h8, 1'b1, 2'b10, 32'hDEAD_BEEF, s + 1);
    pushResp(1'b1, 32'hA000_0010, s + 2);
    pushD(32'h8, 1'b1, 2'b10, 32'hDEAD_BEEF);
    runD();

    // Starvation: 4 stores, forced fetch, 2 remaining stores
    startCycle(s);
    for (int k = 0; k < 4; k++) begin
      pushMem(32'h80 + 4 * k, 1'b1, 2'b00, 32'h1111_0000 + k, s + 1 + 3 * k);
      pushResp(1'b1, 32'hA000_0010, s + 2 + 3 * k);
    end
    pushMem(32'h30, 1'b0, 2'b00, '0, s + 13);
    pushResp(1'b0, 32'hA000_000C, s + 14 + LAT);
    for (int k = 4; k < 6; k++) begin
      pushMem(32'h80 + 4 * k, 1'b1, 2'b00, 32'h1111_0000 + k, s + 16 + LAT + 3 * (k - 4));
      pushResp(1'b1, 32'hA000_0010, s + 17 + LAT + 3 * (k - 4));
    end
    for (int k = 0; k < 6; k++) pushD(32'h80 + 4 * k, 1'b1, 2'b00, 32'h1111_0000 + k);
    ifCmds.push_back(32'h30);
    fork runIf(); runD(); join

    // Contention again: starvation count was cleared, so D wins
    startCycle(s);
    pushMem(32'h44, 1'b0, 2'b00, '0, s + 1);
    pushResp(1'b1, 32'hA000_0011, s + 2 + LAT);
    pushMem(32'h14, 1'b0, 2'b00, '0, s + 4 + LAT);
    pushResp(1'b0, 32'hA000_0005, s + 5 + 2 * LAT);
    pushD(32'h44, 1'b0, 2'b00, '0);
    ifCmds.push_back(32'h14);
    fork runIf(); runD(); join

    // Reset during WAIT: response dropped, outputs cleared
    startCycle(s);
    pushMem(32'h24, 1'b0, 2'b00, '0, s + 1);
    IF_Addr = 32'h24; IF_Req = 1'b1;
    repeat (3) @(negedge Clock);   // now in cycle s+2, state WAIT
    Reset = 1'b0; IF_Req = 1'b0;
    #1 checkAllZero("midreset");
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (8) @(negedge Clock);   // any stray grant hits an empty queue
    startCycle(s);
    pushMem(32'h10, 1'b0, 2'b00, '0, s + 1);
    pushResp(1'b0, 32'h2002_000A, s + 2 + LAT);
    ifCmds.push_back(32'h10);
    runIf();

    // Perf: 2 loads then 3 fetches under contention
    @(negedge Clock) Reset = 1'b0;
    @(negedge Clock) Reset = 1'b1;
    startCycle(s);
    pushMem(32'h0C, 1'b0, 2'b00, '0, s + 1);
    pushResp(1'b1, 32'hA000_0003, s + 2 + LAT);
    pushMem(32'h10, 1'b0, 2'b00, '0, s + 1 + P);
    pushResp(1'b1, 32'h2002_000A, s + 2 + LAT + P);
    for (int k = 0; k < 3; k++) begin
      pushMem(32'h4 * k, 1'b0, 2'b00, '0, s + 1 + (2 + k) * P);
      pushResp(1'b0, 32'hA000_0000 + k, s + 2 + LAT + (2 + k) * P);
    end
    pushD(32'h0C, 1'b0, 2'b00, '0);
    pushD(32'h10, 1'b0, 2'b00, '0);
    for (int k = 0; k < 3; k++) ifCmds.push_back(32'h4 * k);
    fork runIf(); runD(); join
    repeat (2) @(negedge Clock);
`ifdef ARB_PERF_EN
    check("perf_if",    Perf_IF,    32'd3);
    check("perf_d",     Perf_D,     32'd2);
    check("perf_stall", Perf_Stall, 32'(4 * P + LAT));
`else
    check("perf_if",    Perf_IF,    32'd0);
    check("perf_d",     Perf_D,     32'd0);
    check("perf_stall", Perf_Stall, 32'd0);
`endif

    check("resp_queue_empty", 32'(respQ.size()), 32'd0);
    check("mem_queue_empty",  32'(memQ.size()),  32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the IF stage (fetch, read-only) and the MEM stage (load/store).
- Serialises accesses with a request/grant handshake and absorbs memory read latency.
- Drives a stall signal that the pipelined CPU top uses to gate the PC and pipeline-register write enables.
- Sits between the stage logic and the memory macro, clocked by the divided CPU clock.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles from Mem_En to valid Mem_RData; legal range 1..4
STARVE_MAX, 4, consecutive data-side wins while IF waits before IF is forced to win; legal range 1..15

Ports:
Clock  in  1  CPU clock, rising edge
Reset  in  1  asynchronous, active-low reset
IF_Req  in  1  fetch request, level, held until IF_Grant
IF_Addr  in  ADDR_W  fetch address
IF_Grant  out  1  one-cycle pulse, fetch complete
IF_RData  out  DATA_W  fetched word, valid with IF_Grant, held until next IF_Grant
D_Req  in  1  data request, level, held until D_Done
D_Write  in  1  1 = store, 0 = load
D_ByteSel  in  2  access size: 00 word, 01 half, 10 byte
D_Addr  in  ADDR_W  data address
D_WData  in  DATA_W  store data
D_Done  out  1  one-cycle pulse, data access complete
D_RData  out  DATA_W  load data, valid with D_Done, held until next load D_Done
Mem_En  out  1  memory access strobe
Mem_We  out  1  memory write enable
Mem_ByteSel  out  2  forwarded access size
Mem_Addr  out  ADDR_W  memory address
Mem_WData  out  DATA_W  memory write data
Mem_RData  in  DATA_W  memory read data
Stall  out  1  combinational: (IF_Req & ~IF_Grant) | (D_Req & ~D_Done)
Perf_IF  out  32  IF grant count (optional feature)
Perf_D  out  32  data completion count (optional feature)
Perf_Stall  out  32  stall cycle count (optional feature)

Behaviour:
- Reset (async, Reset=0):
  - State goes to IDLE; every output, latched payload, wait counter and starvation counter is cleared to 0.
  - Any in-flight memory response is discarded, including when reset lands mid-transaction.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples the requests. A requester whose Grant/Done is high in this cycle is ignored.
  - Winner selection: D wins if D_Req=1 and (IF_Req=0 or starve_cnt < STARVE_MAX). Otherwise IF wins if IF_Req=1.
  - Latches the winner's address, write flag, ByteSel and WData; next state ISSUE.
  - With no request, stays in IDLE.
- ISSUE (1 cycle):
  - Drives Mem_En=1 with the latched payload. Mem_We=1 only for a data store.
  - Store: next state RESP. Otherwise WAIT with wait_cnt=MEM_LAT-1.
- WAIT:
  - Decrements wait_cnt. At wait_cnt==0, registers Mem_RData into the winner's RData register; next state RESP.
  - Mem_En=0 throughout WAIT.
- RESP (1 cycle):
  - Pulses the winner's IF_Grant or D_Done; next state IDLE.
- Latency from request sampled in IDLE (cycle t):
  - Load/fetch: Grant/Done in cycle t+2+MEM_LAT.
  - Store: D_Done in cycle t+2.
- Starvation counter:
  - Increments, saturating at 15, each time D wins while IF_Req=1.
  - Clears when IF is granted.
- Payload changes after the IDLE sample are ignored.
- Requester dropping Req mid-transaction is a protocol violation. The transaction still completes and the pulse is still issued.
- IF_RData and D_RData hold their values between completions. A store leaves D_RData unchanged.
- Mem_Addr, Mem_WData and Mem_ByteSel hold the last latched payload when Mem_En=0.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined:
  - Three 32-bit wrapping counters: Perf_IF +1 per IF_Grant, Perf_D +1 per D_Done, Perf_Stall +1 per cycle with Stall=1.
  - All cleared by Reset.
- Undefined:
  - The Perf_* ports remain and are tied to 0; no counter logic is synthesised.

Test Plan:
- IF_Req=1, IF_Addr=0x10, Mem_RData=0x2002000A, MEM_LAT=1, D_Req=0 -> Mem_En high 1 cycle after sampling, IF_Grant pulse 3 cycles after sampling, IF_RData=0x2002000A, Stall=1 until the Grant cycle.
- IF_Req and D_Req both high, D load at 0x40, starve_cnt=0 -> D issued first, D_Done, then IF issued; IF_Grant 3+MEM_LAT cycles after D_Done.
- D_Req held high for 6 back-to-back stores with IF_Req high, STARVE_MAX=4 -> 4 stores, then IF granted, then remaining 2 stores; starve_cnt returns to 0.
- Store D_Addr=0x8, D_WData=0xDEADBEEF, D_ByteSel=10 -> one Mem_En/Mem_We cycle with Mem_ByteSel=10, D_Done 2 cycles after sampling, D_RData unchanged.
- Reset asserted during WAIT with MEM_LAT=4 -> immediate IDLE, all outputs 0, no Grant pulse after release; a new IF_Req then completes normally.
- ARB_PERF_EN defined, 3 fetches plus 2 loads with MEM_LAT=2 -> Perf_IF=3, Perf_D=2, Perf_Stall equals the Stall-high cycle count; undefined -> all Perf_* read 0.
